// File: rtl/imba_menu_cursor_ctrl.sv
// Menu cursor controller: button edges drive a cursor over a 2x2 box menu and the
// Axis/Grid/Tick display toggles, plus registered per-pixel box/border flags.
// Optional build macro CURSOR_WRAP_EN: cursor moves wrap instead of clamping.
module imba_menu_cursor_ctrl #(
    parameter int BOX_X0       = 320,
    parameter int BOX_Y0       = 256,
    parameter int BOX_W        = 160,
    parameter int BOX_H        = 120,
    parameter int GAP          = 32,
    parameter int BORDER       = 4,
    parameter int FLASH_CYCLES = 1000000
) (
    input  logic        CLK_VGA,
    input  logic        RESET,
    input  logic        MENU_EN,
    input  logic        BTN_U,
    input  logic        BTN_D,
    input  logic        BTN_L,
    input  logic        BTN_R,
    input  logic        BTN_C,
    input  logic [11:0] VGA_HORZ_COORD,
    input  logic [11:0] VGA_VERT_COORD,
    output logic        Axis_On,
    output logic        Grid_On,
    output logic        Tick_On,
    output logic [3:0]  Condition_For_Box,
    output logic        Condition_For_Cursor_Border,
    output logic [1:0]  Cursor_Index
);

    localparam int CW = $clog2(FLASH_CYCLES + 1);
    localparam logic [CW-1:0] FLASH_LOAD = CW'(FLASH_CYCLES);

    // Box bounds: _LO inclusive, _HI exclusive; _BL/_BH are the inner border limits.
    localparam logic [11:0] C0_LO = 12'(BOX_X0);
    localparam logic [11:0] C0_HI = 12'(BOX_X0 + BOX_W);
    localparam logic [11:0] C1_LO = 12'(BOX_X0 + BOX_W + GAP);
    localparam logic [11:0] C1_HI = 12'(BOX_X0 + 2 * BOX_W + GAP);
    localparam logic [11:0] R0_LO = 12'(BOX_Y0);
    localparam logic [11:0] R0_HI = 12'(BOX_Y0 + BOX_H);
    localparam logic [11:0] R1_LO = 12'(BOX_Y0 + BOX_H + GAP);
    localparam logic [11:0] R1_HI = 12'(BOX_Y0 + 2 * BOX_H + GAP);
    localparam logic [11:0] C0_BL = 12'(BOX_X0 + BORDER);
    localparam logic [11:0] C0_BH = 12'(BOX_X0 + BOX_W - BORDER);
    localparam logic [11:0] C1_BL = 12'(BOX_X0 + BOX_W + GAP + BORDER);
    localparam logic [11:0] C1_BH = 12'(BOX_X0 + 2 * BOX_W + GAP - BORDER);
    localparam logic [11:0] R0_BL = 12'(BOX_Y0 + BORDER);
    localparam logic [11:0] R0_BH = 12'(BOX_Y0 + BOX_H - BORDER);
    localparam logic [11:0] R1_BL = 12'(BOX_Y0 + BOX_H + GAP + BORDER);
    localparam logic [11:0] R1_BH = 12'(BOX_Y0 + 2 * BOX_H + GAP - BORDER);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_NAV     = 2'd1,
        ST_CONFIRM = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      cursor_q, cursor_d;
    logic            axis_q, axis_d;
    logic            grid_q, grid_d;
    logic            tick_q, tick_d;
    logic [4:0]      btn_prev_q;
    logic [4:0]      btn_s;
    logic [4:0]      edge_s;
    logic [3:0]      box_q, box_d;
    logic            border_q, border_d;

    logic [1:0]      in_col_s;
    logic [1:0]      in_row_s;
    logic [3:0]      in_box_s;
    logic [11:0]     cx_bl_s, cx_bh_s, cy_bl_s, cy_bh_s;
    logic            near_edge_s;

    // edges = {U, D, L, R}; only the highest-priority edge moves the cursor
    function automatic logic [1:0] cursor_move(input logic [1:0] cur, input logic [3:0] edges);
        logic [1:0] nxt;
        nxt = cur;
`ifdef CURSOR_WRAP_EN
        if (edges[3] || edges[2]) begin
            nxt[1] = ~cur[1];
        end else if (edges[1] || edges[0]) begin
            nxt[0] = ~cur[0];
        end else begin
            nxt = cur;
        end
`else
        if (edges[3]) begin
            nxt[1] = 1'b0;
        end else if (edges[2]) begin
            nxt[1] = 1'b1;
        end else if (edges[1]) begin
            nxt[0] = 1'b0;
        end else if (edges[0]) begin
            nxt[0] = 1'b1;
        end else begin
            nxt = cur;
        end
`endif
        return nxt;
    endfunction

    assign btn_s  = {BTN_C, BTN_U, BTN_D, BTN_L, BTN_R};
    assign edge_s = btn_s & ~btn_prev_q;

    // Menu FSM, cursor movement and toggle actions
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cursor_d = cursor_q;
        axis_d   = axis_q;
        grid_d   = grid_q;
        tick_d   = tick_q;
        if (!MENU_EN) begin
            state_d = ST_IDLE;
            cnt_d   = {CW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_NAV;
                end
                ST_NAV: begin
                    if (edge_s[4]) begin
                        state_d = ST_CONFIRM;
                        cnt_d   = FLASH_LOAD;
                        case (cursor_q)
                            2'd0:    axis_d = ~axis_q;
                            2'd1:    grid_d = ~grid_q;
                            2'd2:    tick_d = ~tick_q;
                            default: begin
                                axis_d = 1'b0;
                                grid_d = 1'b0;
                                tick_d = 1'b0;
                            end
                        endcase
                    end else begin
                        cursor_d = cursor_move(cursor_q, edge_s[3:0]);
                    end
                end
                ST_CONFIRM: begin
                    if (cnt_q <= CW'(1'b1)) begin
                        state_d = ST_NAV;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        cnt_d = cnt_q - CW'(1'b1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {CW{1'b0}};
                end
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge CLK_VGA) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CW{1'b0}};
            cursor_q   <= 2'd0;
            axis_q     <= 1'b1;
            grid_q     <= 1'b0;
            tick_q     <= 1'b0;
            btn_prev_q <= 5'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cursor_q   <= cursor_d;
            axis_q     <= axis_d;
            grid_q     <= grid_d;
            tick_q     <= tick_d;
            btn_prev_q <= btn_s;
        end
    end

    // Pixel classification against the box grid and the cursor box border
    always_comb begin
        in_col_s[0] = (VGA_HORZ_COORD >= C0_LO) && (VGA_HORZ_COORD < C0_HI);
        in_col_s[1] = (VGA_HORZ_COORD >= C1_LO) && (VGA_HORZ_COORD < C1_HI);
        in_row_s[0] = (VGA_VERT_COORD >= R0_LO) && (VGA_VERT_COORD < R0_HI);
        in_row_s[1] = (VGA_VERT_COORD >= R1_LO) && (VGA_VERT_COORD < R1_HI);
        in_box_s    = {in_row_s[1] & in_col_s[1], in_row_s[1] & in_col_s[0],
                       in_row_s[0] & in_col_s[1], in_row_s[0] & in_col_s[0]};
        cx_bl_s     = cursor_q[0] ? C1_BL : C0_BL;
        cx_bh_s     = cursor_q[0] ? C1_BH : C0_BH;
        cy_bl_s     = cursor_q[1] ? R1_BL : R0_BL;
        cy_bh_s     = cursor_q[1] ? R1_BH : R0_BH;
        near_edge_s = (VGA_HORZ_COORD < cx_bl_s) || (VGA_HORZ_COORD >= cx_bh_s) ||
                      (VGA_VERT_COORD < cy_bl_s) || (VGA_VERT_COORD >= cy_bh_s);
        border_d    = MENU_EN && in_box_s[cursor_q] && near_edge_s && (state_q != ST_CONFIRM);
        if (MENU_EN) begin
            box_d = in_box_s & {4{~border_d}};
        end else begin
            box_d = 4'd0;
        end
    end

    // Registered pixel flags
    always_ff @(posedge CLK_VGA) begin
        if (RESET) begin
            box_q    <= 4'd0;
            border_q <= 1'b0;
        end else begin
            box_q    <= box_d;
            border_q <= border_d;
        end
    end

    assign Axis_On                     = axis_q;
    assign Grid_On                     = grid_q;
    assign Tick_On                     = tick_q;
    assign Cursor_Index                = cursor_q;
    assign Condition_For_Box           = box_q;
    assign Condition_For_Cursor_Border = border_q;

endmodule
